art_mask_sequencer: RTL and testbench
=====================================

# art_mask_sequencer

Time-sequenced XOR-mask controller for the silicon-art pin datapath. It replaces the fixed `ui_in ^ 8'hAA` output pattern with a programmable table of masks, stepped at a configurable rate. Pin-facing data enters on `data_in` and leaves registered on `data_out`, so the top level can show animated patterns on `uo_out`. Configuration is written through a valid/ready port, driven from `uio_in` by top-level glue.

## Interface
- `DEPTH`, 4: mask table entries; power of two, at least 2. AW = log2(DEPTH).
- `PRESCALE_W`, 16: width of the step divider.
- `DEFAULT_MASK`, 8'hAA: mask used in IDLE; also the reset value of every table entry.

- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `run`  in  1  level; request sequencing.
- `clear`  in  1  level; force IDLE, zero index and prescaler. Table contents are kept.
- `step_div`  in  PRESCALE_W  cycles per step minus 1; sampled live.
- `seq_last`  in  AW  last table index before wrap to 0.
- `cfg_valid`  in  1  table write request.
- `cfg_ready`  out  1  table write accepted when high.
- `cfg_addr`  in  AW  table entry to write.
- `cfg_data`  in  8  mask value to write.
- `data_in`  in  8  pin data to be masked.
- `data_out`  out  8  registered `data_in ^ cur_mask`.
- `mask_out`  out  8  registered `cur_mask`; aligned with `data_out`.
- `index`  out  AW  current table index.
- `running`  out  1  high in state RUN.

## Operation
- **State machine:** IDLE, RUN, PAUSE. Encoding is free.
  - IDLE → RUN when `run`=1. Index and prescaler are already 0.
  - RUN → PAUSE when `run`=0. Index and prescaler are held.
  - PAUSE → RUN when `run`=1. Resume from the held index and prescaler.
  - Any state → IDLE when `clear`=1. Index and prescaler go to 0. `clear` beats `run` when both are high.
- **cur_mask:** `DEFAULT_MASK` in IDLE; `table[index]` in RUN and PAUSE.
- **Prescaler (RUN only):**
  - Counts 0..`step_div`.
  - When the count equals `step_div`, it returns to 0 and index advances.
  - `step_div`=0 advances index every cycle.
  - If `step_div` is lowered below the current count, the next cycle is treated as terminal: advance, then count resets.
- **Index advance:**
  - If index ≥ `seq_last`, index goes to 0; otherwise index+1.
  - This covers a `seq_last` change to a value below the current index.
  - `seq_last`=0 holds index at 0.
- **Config handshake:**
  - `cfg_ready` = (state != RUN), decoded directly from the state register.
  - A write commits on a rising edge with `cfg_valid && cfg_ready`.
  - `cfg_valid` while `cfg_ready`=0 is ignored. No queuing; the requester must hold `cfg_valid` until ready.
  - A PAUSE write to the current index changes `cur_mask` on the next cycle.
- **Datapath:** every cycle, `data_out <= data_in ^ cur_mask` and `mask_out <= cur_mask`.

## Timing
- **Reset (`rst` high at an edge):**
  - State IDLE, index 0, prescaler 0.
  - All table entries set to `DEFAULT_MASK`.
  - `data_out`=0, `mask_out`=0, `running`=0, `cfg_ready`=1.
  - Reset mid-RUN discards the sequence and clears the table.
- **Datapath latency:** 1 cycle from `data_in` to `data_out`. `mask_out` is always the mask applied to the `data_out` value it accompanies.
- **State change:** `run` rising in IDLE at edge N gives `running`=1 and `cfg_ready`=0 after edge N.
  - The first index advance (0→1) occurs at edge N+1+`step_div`.
  - Mask `table[0]` first appears on `mask_out` after edge N+1.
- **Table write:** a write at edge N is visible in `cur_mask` from cycle N+1, if its address is current.
- **Simultaneous events:**
  - `clear` and `cfg_valid` in PAUSE: the write commits and the state goes to IDLE.
  - `run` falling on a terminal prescaler cycle: PAUSE takes priority and there is no advance.

## Test plan
- **Reset and default:** assert `rst` one cycle, then drive `data_in`=8'h0F with `run`=0 → after reset `data_out`=0; one cycle later `data_out`=8'hA5, `mask_out`=8'hAA, `cfg_ready`=1.
- **Program and sequence:**
  - Write {8'h01, 8'h02, 8'h04, 8'h08} to addrs 0–3; set `seq_last`=3, `step_div`=2, `data_in`=0, `run`=1.
  - Required: `mask_out` sequence 01,01,01,02,02,02,04,04,04,08,08,08,01… with index wrap 3→0.
- **Handshake blocking:** in RUN, hold `cfg_valid` with addr 0, data 8'hFF → `cfg_ready`=0 and table unchanged. Drop `run` → the write commits on the first PAUSE cycle, and `mask_out`=8'hFF on the next cycle if index=0.
- **Pause/resume:** pause at index 2 with prescaler 1, hold 10 cycles → index stays 2. Resume → advance after exactly 1 more cycle (`step_div`=2).
- **Clear priority:** `run`=1 and `clear`=1 together at index 3 → IDLE, index 0, `mask_out`=8'hAA next cycle, table contents preserved.
- **Boundary:** `step_div`=0 with `seq_last`=1 → index toggles 0,1,0,1 every cycle. Then lower `seq_last` from 3 to 1 at index 3 → index goes to 0 at the next step.

Source files
------------

// File: rtl/art_mask_sequencer.sv
// -----------------------------------------------------------------------------
// art_mask_sequencer
//
// Time-sequenced XOR-mask controller for the silicon-art pin datapath.
// Pin data on data_in is XORed with the current mask and registered onto
// data_out. The current mask is DEFAULT_MASK while idle, or an entry of a
// small programmable table while sequencing. The table index steps once every
// (step_div + 1) cycles in RUN and wraps after seq_last. The table is written
// through a valid/ready port that only accepts writes outside RUN.
//
// Ports
//   clk        in   clock, single domain
//   rst        in   synchronous active-high reset
//   run        in   level, request sequencing (low pauses)
//   clear      in   level, force IDLE and zero index/prescaler (table kept)
//   step_div   in   cycles per step minus 1, sampled live
//   seq_last   in   last table index before wrap to 0
//   cfg_valid  in   table write request
//   cfg_ready  out  table write accepted when high (state != RUN)
//   cfg_addr   in   table entry to write
//   cfg_data   in   mask value to write
//   data_in    in   pin data to be masked
//   data_out   out  registered data_in ^ cur_mask
//   mask_out   out  registered cur_mask, aligned with data_out
//   index      out  current table index
//   running    out  high in state RUN
// -----------------------------------------------------------------------------
module art_mask_sequencer #(
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned PRESCALE_W   = 16,
   parameter logic [7:0]  DEFAULT_MASK = 8'hAA,
   localparam int unsigned AW          = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  run,
   input  logic                  clear,
   input  logic [PRESCALE_W-1:0] step_div,
   input  logic [AW-1:0]         seq_last,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   input  logic [AW-1:0]         cfg_addr,
   input  logic [7:0]            cfg_data,
   input  logic [7:0]            data_in,
   output logic [7:0]            data_out,
   output logic [7:0]            mask_out,
   output logic [AW-1:0]         index,
   output logic                  running
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic [AW-1:0]         index_q, index_d;
   logic [PRESCALE_W-1:0] pre_q, pre_d;
   logic [7:0]            table_q [DEPTH];
   logic [7:0]            table_d [DEPTH];
   logic [7:0]            data_out_q, data_out_d;
   logic [7:0]            mask_out_q, mask_out_d;

   logic [7:0]            cur_mask;
   logic                  wr_en;
   logic                  terminal;
   logic [AW-1:0]         next_index;

   // Handshake is a pure decode of the state register so it never depends on
   // this cycle's inputs.
   assign cfg_ready = (state_q != ST_RUN);
   assign running   = (state_q == ST_RUN);
   assign index     = index_q;
   assign data_out  = data_out_q;
   assign mask_out  = mask_out_q;

   assign cur_mask  = (state_q == ST_IDLE) ? DEFAULT_MASK : table_q[index_q];
   assign wr_en     = cfg_valid && cfg_ready;

   // ">=" rather than "==": if step_div is lowered below the running count,
   // this cycle is treated as terminal instead of counting up to wrap-around.
   assign terminal  = (pre_q >= step_div);

   // ">=" also absorbs a seq_last that was lowered below the current index.
   assign next_index = (index_q >= seq_last) ? '0 : index_q + AW'(1);

   // Table write port. A write in PAUSE to the current index shows up in
   // cur_mask on the very next cycle because cur_mask reads table_q directly.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can
      // leave it unassigned and infer a latch.
      table_d = table_q;
      if (wr_en) begin
         table_d[cfg_addr] = cfg_data;
      end
   end

   // Sequencer state, index and prescaler.
   always_comb begin
      state_d = state_q;
      index_d = index_q;
      pre_d   = pre_q;

      if (clear) begin
         // clear beats run in every state.
         state_d = ST_IDLE;
         index_d = '0;
         pre_d   = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (run) begin
                  state_d = ST_RUN;
               end
            end
            ST_RUN: begin
               // Pausing wins over a terminal count: no advance on that edge.
               if (!run) begin
                  state_d = ST_PAUSE;
               end else if (terminal) begin
                  pre_d   = '0;
                  index_d = next_index;
               end else begin
                  pre_d   = pre_q + PRESCALE_W'(1);
               end
            end
            ST_PAUSE: begin
               if (run) begin
                  state_d = ST_RUN;
               end
            end
            default: begin
               state_d = ST_IDLE;
               index_d = '0;
               pre_d   = '0;
            end
         endcase
      end
   end

   // Output datapath: mask_out is the mask applied to the data_out it
   // accompanies.
   always_comb begin
      data_out_d = data_in ^ cur_mask;
      mask_out_d = cur_mask;
   end

   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples the pre-edge values computed above.
      if (rst) begin
         state_q    <= ST_IDLE;
         index_q    <= '0;
         pre_q      <= '0;
         data_out_q <= '0;
         mask_out_q <= '0;
         // NOTE: the table is deliberately reset; it is small flop storage and
         // reset must restore DEFAULT_MASK in every entry, so it cannot be a
         // RAM macro without reset.
         for (int i = 0; i < DEPTH; i++) begin
            table_q[i] <= DEFAULT_MASK;
         end
      end else begin
         state_q    <= state_d;
         index_q    <= index_d;
         pre_q      <= pre_d;
         data_out_q <= data_out_d;
         mask_out_q <= mask_out_d;
         for (int i = 0; i < DEPTH; i++) begin
            table_q[i] <= table_d[i];
         end
      end
   end

endmodule

// File: tb/tb_art_mask_sequencer.sv
// -----------------------------------------------------------------------------
// tb_art_mask_sequencer
//
// Stimulus is driven on the falling edge. A reference model advances on every
// rising edge from the sampled inputs and pushes the expected registered
// outputs into a queue; an independent monitor pops and compares them 1 ns
// after the rising edge. Directed checks against hand-derived constants are
// made on falling edges, followed by a long randomized run.
// -----------------------------------------------------------------------------
module tb_art_mask_sequencer;

   localparam int DEPTH = 4;
   localparam int PW    = 16;
   localparam int AW    = 2;
   localparam logic [7:0] DEF = 8'hAA;

   logic          clk = 1'b0;
   logic          rst;
   logic          run;
   logic          clear;
   logic [PW-1:0] step_div;
   logic [AW-1:0] seq_last;
   logic          cfg_valid;
   logic          cfg_ready;
   logic [AW-1:0] cfg_addr;
   logic [7:0]    cfg_data;
   logic [7:0]    data_in;
   logic [7:0]    data_out;
   logic [7:0]    mask_out;
   logic [AW-1:0] index;
   logic          running;

   art_mask_sequencer #(
      .DEPTH(DEPTH),
      .PRESCALE_W(PW),
      .DEFAULT_MASK(DEF)
   ) dut (
      .clk(clk),
      .rst(rst),
      .run(run),
      .clear(clear),
      .step_div(step_div),
      .seq_last(seq_last),
      .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready),
      .cfg_addr(cfg_addr),
      .cfg_data(cfg_data),
      .data_in(data_in),
      .data_out(data_out),
      .mask_out(mask_out),
      .index(index),
      .running(running)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model: a behavioural description of the sequencer. "mode" is
   // what the controller is doing, "dwell" is how many counted cycles have
   // been spent on the current table entry.
   // ---------------------------------------------------------------------------
   typedef struct {
      int d;
      int m;
      int idx;
      int run_o;
      int rdy;
   } exp_t;

   exp_t sb_q[$];

   localparam int MODE_IDLE  = 0;
   localparam int MODE_RUN   = 1;
   localparam int MODE_PAUSE = 2;

   int m_mode = MODE_IDLE;
   int m_idx  = 0;
   int m_dwell = 0;
   int m_tbl [DEPTH];

   task automatic model_edge();
      exp_t e;
      int   mask_now;
      if (rst) begin
         m_mode  = MODE_IDLE;
         m_idx   = 0;
         m_dwell = 0;
         for (int i = 0; i < DEPTH; i++) m_tbl[i] = int'(DEF);
         e.d = 0;
         e.m = 0;
      end else begin
         mask_now = (m_mode == MODE_IDLE) ? int'(DEF) : m_tbl[m_idx];
         e.d = int'(data_in) ^ mask_now;
         e.m = mask_now;
         if (cfg_valid && m_mode != MODE_RUN) m_tbl[int'(cfg_addr)] = int'(cfg_data);
         if (clear) begin
            m_mode  = MODE_IDLE;
            m_idx   = 0;
            m_dwell = 0;
         end else if (m_mode == MODE_IDLE) begin
            if (run) m_mode = MODE_RUN;
         end else if (m_mode == MODE_PAUSE) begin
            if (run) m_mode = MODE_RUN;
         end else if (!run) begin
            m_mode = MODE_PAUSE;
         end else if (m_dwell >= int'(step_div)) begin
            m_dwell = 0;
            m_idx   = (m_idx >= int'(seq_last)) ? 0 : m_idx + 1;
         end else begin
            m_dwell = m_dwell + 1;
         end
      end
      e.idx   = m_idx;
      e.run_o = (m_mode == MODE_RUN) ? 1 : 0;
      e.rdy   = (m_mode == MODE_RUN) ? 0 : 1;
      sb_q.push_back(e);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_edge();
      end
   end

   // Monitor: pops one expectation per registered output update.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("sb_data_out", 32'(data_out), 32'(e.d));
            check("sb_mask_out", 32'(mask_out), 32'(e.m));
            check("sb_index", 32'(index), 32'(e.idx));
            check("sb_running", 32'(running), 32'(e.run_o));
            check("sb_cfg_ready", 32'(cfg_ready), 32'(e.rdy));
         end
      end
   end

   // Bounded wait for the index to reach a value, sampled on falling edges.
   task automatic wait_index(input int target, input string name);
      bit found = 0;
      for (int n = 0; n < 40; n++) begin
         if (int'(index) == target) begin
            found = 1;
            break;
         end
         @(negedge clk);
      end
      check(name, 32'(found), 32'd1);
   endtask

   int seq_exp [13] = '{1, 1, 1, 2, 2, 2, 4, 4, 4, 8, 8, 8, 1};

   // ---------------------------------------------------------------------------
   // Driver with directed checks.
   // ---------------------------------------------------------------------------
   initial begin
      rst       = 1'b1;
      run       = 1'b0;
      clear     = 1'b0;
      step_div  = '0;
      seq_last  = '0;
      cfg_valid = 1'b0;
      cfg_addr  = '0;
      cfg_data  = '0;
      data_in   = '0;

      // Reset and default mask.
      @(negedge clk);
      check("rst_data_out", 32'(data_out), 32'h0);
      check("rst_cfg_ready", 32'(cfg_ready), 32'h1);
      rst     = 1'b0;
      data_in = 8'h0F;
      @(negedge clk);
      check("idle_data_out", 32'(data_out), 32'hA5);
      check("idle_mask_out", 32'(mask_out), 32'hAA);
      check("idle_cfg_ready", 32'(cfg_ready), 32'h1);

      // Program the table.
      for (int i = 0; i < 4; i++) begin
         cfg_valid = 1'b1;
         cfg_addr  = AW'(i);
         cfg_data  = 8'(1 << i);
         @(negedge clk);
      end
      cfg_valid = 1'b0;
      seq_last  = 2'd3;
      step_div  = 16'd2;
      data_in   = 8'h00;
      run       = 1'b1;
      @(negedge clk);
      check("run_running", 32'(running), 32'h1);
      check("run_cfg_ready", 32'(cfg_ready), 32'h0);
      for (int k = 0; k < 13; k++) begin
         @(negedge clk);
         check($sformatf("seq_mask_%0d", k), 32'(mask_out), 32'(seq_exp[k]));
      end

      // Handshake blocked in RUN, commits on first PAUSE cycle.
      cfg_valid = 1'b1;
      cfg_addr  = 2'd0;
      cfg_data  = 8'hFF;
      @(negedge clk);
      check("blocked_ready", 32'(cfg_ready), 32'h0);
      wait_index(0, "wait_idx0");
      run = 1'b0;
      @(negedge clk);
      check("pause_ready", 32'(cfg_ready), 32'h1);
      check("pause_index", 32'(index), 32'h0);
      @(negedge clk);
      cfg_valid = 1'b0;
      @(negedge clk);
      check("pause_write_mask", 32'(mask_out), 32'hFF);

      // Pause at index 2 with prescaler 1, then resume.
      run = 1'b1;
      @(negedge clk);
      wait_index(2, "wait_idx2");
      @(negedge clk);
      run = 1'b0;
      repeat (11) @(negedge clk);
      check("hold_index", 32'(index), 32'h2);
      run = 1'b1;
      @(negedge clk);
      check("resume_idx_a", 32'(index), 32'h2);
      @(negedge clk);
      check("resume_idx_b", 32'(index), 32'h2);
      @(negedge clk);
      check("resume_advance", 32'(index), 32'h3);

      // Clear beats run.
      clear = 1'b1;
      @(negedge clk);
      check("clear_index", 32'(index), 32'h0);
      check("clear_running", 32'(running), 32'h0);
      clear = 1'b0;
      run   = 1'b0;
      @(negedge clk);
      check("clear_mask", 32'(mask_out), 32'hAA);

      // step_div = 0 with seq_last = 1 toggles the index every cycle.
      step_div = 16'd0;
      seq_last = 2'd1;
      run      = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         check($sformatf("toggle_%0d", k), 32'(index), 32'(k % 2));
         @(negedge clk);
      end

      // Lowering seq_last below the current index wraps at the next step.
      seq_last = 2'd3;
      wait_index(2, "wait_idx2_b");
      seq_last = 2'd1;
      @(negedge clk);
      check("lower_last_from2", 32'(index), 32'h0);
      seq_last = 2'd3;
      wait_index(3, "wait_idx3");
      seq_last = 2'd1;
      @(negedge clk);
      check("lower_last_from3", 32'(index), 32'h0);

      // Randomized run against the model.
      run = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         rst       = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 7) == 0) run = ~run;
         clear     = ($urandom_range(0, 49) == 0);
         cfg_valid = ($urandom_range(0, 3) == 0);
         cfg_addr  = AW'($urandom_range(0, DEPTH - 1));
         cfg_data  = 8'($urandom);
         data_in   = 8'($urandom);
         if ($urandom_range(0, 19) == 0) step_div = PW'($urandom_range(0, 4));
         if ($urandom_range(0, 29) == 0) seq_last = AW'($urandom_range(0, DEPTH - 1));
         @(negedge clk);
      end
      rst       = 1'b0;
      run       = 1'b0;
      clear     = 1'b0;
      cfg_valid = 1'b0;
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
